inert_seq: RTL and testbench

- Sequencer that owns the SPI_mnrch transaction port and drives the iNEMO inertial sensor autonomously.
- After reset it performs these steps in order:
  - waits a power-up delay;
  - checks the WHO_AM_I ID;
  - writes the configuration registers;
  - then services each data-ready INT by reading yaw-rate low/high bytes.
- Presents an assembled 16-bit yaw rate with a one-cycle valid pulse to the heading/integration logic downstream.

---
 rtl/inert_pkg.sv | 11 +
 rtl/inert_seq_int_sync.sv | 12 +
 rtl/inert_seq.sv | 99 +++++++++
 tb/tb_inert_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/inert_pkg.sv
// inert_pkg: sequencer states, SPI command words and default sensor ID for inert_seq
package inert_pkg;
  typedef enum logic [3:0] {PWRUP, ID, CFG0, CFG1, CFG2, WAIT_INT, RD_YL, RD_YH, HALT} state_t;
  localparam logic [15:0] CMD_WHOAMI = 16'h8F00;
  localparam logic [15:0] CMD_INTCFG = 16'h0D02;
  localparam logic [15:0] CMD_ODR    = 16'h1160;
  localparam logic [15:0] CMD_RND    = 16'h1440;
  localparam logic [15:0] CMD_YL     = 16'hA600;
  localparam logic [15:0] CMD_YH     = 16'hA700;
  localparam logic [7:0]  ID_EXP_DEF = 8'h6A;
endpackage

// File: rtl/inert_seq_int_sync.sv
// int_sync: two-flop synchronizer for the asynchronous sensor interrupt
module int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (!rst_n) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/inert_seq.sv
// inert_seq: autonomous iNEMO bring-up and yaw-rate reader driving the SPI_mnrch port
module inert_seq import inert_pkg::*; #(
  parameter logic [15:0] PWRUP_CYC = 16'hFFFF,
  parameter logic [7:0]  ID_EXP    = ID_EXP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        init_done,
  output logic        id_err
);
  state_t      state;
  logic [15:0] timer;
  logic [7:0]  yl_hold;
  logic        int_s;
  logic        fin;
  logic        unused_rd_hi;
  int_sync u_int_sync (.clk(clk), .rst_n(rst_n), .d(INT), .q(int_s));
  assign unused_rd_hi = ^rd_data[15:8];
  // a done coinciding with our own start pulse cannot belong to this transaction
  assign fin = done & ~wrt;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= PWRUP;
      timer     <= '0;
      wrt       <= 1'b0;
      cmd       <= '0;
      yaw_rt    <= '0;
      vld       <= 1'b0;
      init_done <= 1'b0;
      id_err    <= 1'b0;
      yl_hold   <= '0;
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      case (state)
        PWRUP:
          if (timer == PWRUP_CYC - 16'd1) begin
            state <= ID;
            wrt   <= 1'b1;
            cmd   <= CMD_WHOAMI;
          end else timer <= timer + 16'd1;
        ID:
          if (fin) begin
            if (rd_data[7:0] == ID_EXP) begin
              state <= CFG0;
              wrt   <= 1'b1;
              cmd   <= CMD_INTCFG;
            end else begin
              state  <= HALT;
              id_err <= 1'b1;
            end
          end
        CFG0:
          if (fin) begin
            state <= CFG1;
            wrt   <= 1'b1;
            cmd   <= CMD_ODR;
          end
        CFG1:
          if (fin) begin
            state <= CFG2;
            wrt   <= 1'b1;
            cmd   <= CMD_RND;
          end
        CFG2:
          if (fin) begin
            state     <= WAIT_INT;
            init_done <= 1'b1;
          end
        WAIT_INT:
          if (int_s) begin
            state <= RD_YL;
            wrt   <= 1'b1;
            cmd   <= CMD_YL;
          end
        RD_YL:
          if (fin) begin
            state   <= RD_YH;
            yl_hold <= rd_data[7:0];
            wrt     <= 1'b1;
            cmd     <= CMD_YH;
          end
        RD_YH:
          if (fin) begin
            state  <= WAIT_INT;
            yaw_rt <= {rd_data[7:0], yl_hold};
            vld    <= 1'b1;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_inert_seq.sv
// tb_inert_seq: sensor/SPI model, transaction-level reference checker and directed scenarios
module tb_inert_seq;
  localparam logic [15:0] PW = 16'd16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] yaw_rt;
  logic        vld;
  logic        init_done;
  logic        id_err;

  inert_seq #(.PWRUP_CYC(PW), .ID_EXP(8'h6A)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .yaw_rt(yaw_rt), .vld(vld), .init_done(init_done), .id_err(id_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // edge-sampled history used by the models
  logic       rst_e = 1'b0;
  logic [2:0] int_h = 3'b000;
  int         rel = 0;
  always @(posedge clk) begin
    rst_e <= rst_n;
    int_h <= {int_h[1:0], INT};
    rel   <= rst_n ? rel + 1 : 0;
  end

  // sensor + SPI_mnrch model
  logic [7:0]  id_val = 8'h6A, yl_val = 8'h00, yh_val = 8'h00;
  bit          rand_int = 0, rand_yaw = 0, lat_fix = 1, int_hold = 0, int_pulse = 0;
  bit          int_pend = 0, hold_q = 0, s_pend = 0;
  int          s_cnt = 0, first_rel = -1, wrt_total = 0, vld_cnt = 0;
  logic [15:0] s_cmd = 16'h0, s_resp = 16'h0;
  logic [15:0] wlog[$];
  initial forever begin
    @(posedge clk); #1;
    done = 1'b0;
    if (!rst_e) begin
      s_pend = 0; int_pend = 0; first_rel = -1; wlog.delete();
    end else begin
      if (int_hold && !hold_q) int_pend = 1;
      if (rand_int && !int_pend && $urandom_range(0, 39) == 0) int_pend = 1;
      if (s_pend) begin
        s_cnt--;
        if (s_cnt == 0) begin
          done = 1'b1; rd_data = s_resp; s_pend = 0;
          if (s_cmd == 16'hA700) int_pend = 0;
        end
      end
      if (wrt) begin
        if (wlog.size() == 0) first_rel = rel;
        wlog.push_back(cmd); wrt_total++;
        s_pend = 1; s_cmd = cmd; s_cnt = lat_fix ? 4 : int'($urandom_range(1, 4));
        if (rand_yaw && cmd == 16'hA600) yl_val = 8'($urandom);
        if (rand_yaw && cmd == 16'hA700) yh_val = 8'($urandom);
        s_resp = {8'($urandom), cmd[15:8] == 8'h8F ? id_val : cmd[15:8] == 8'hA6 ? yl_val :
                  cmd[15:8] == 8'hA7 ? yh_val : 8'($urandom)};
      end
      if (vld) vld_cnt++;
    end
    hold_q = int_hold;
    INT = int_pend | int_pulse;
  end

  // transaction-level reference: which command must come next and what the outputs owe
  int          n_txn = 0, cfg_cnt = 0;
  bit          pend = 0, id_bad = 0, vld_due = 0, prev_wrt = 0;
  logic [15:0] pend_cmd = 16'h0, m_yaw = 16'h0, exp_c;
  logic [7:0]  m_yl = 8'h0;
  function automatic logic [15:0] exp_cmd(input int n);
    logic [15:0] init_seq [4] = '{16'h8F00, 16'h0D02, 16'h1160, 16'h1440};
    return n < 4 ? init_seq[n] : ((n - 4) % 2 == 1 ? 16'hA700 : 16'hA600);
  endfunction
  always @(negedge clk) begin
    if (!rst_e) begin
      chk("rst_wrt", wrt, 0); chk("rst_cmd", cmd, 0); chk("rst_yaw", yaw_rt, 0);
      chk("rst_vld", vld, 0); chk("rst_init_done", init_done, 0); chk("rst_id_err", id_err, 0);
      n_txn = 0; cfg_cnt = 0; pend = 0; id_bad = 0; vld_due = 0; prev_wrt = 0; m_yaw = 0; m_yl = 0;
    end else begin
      chk("vld", vld, vld_due);
      chk("yaw_rt", yaw_rt, m_yaw);
      chk("init_done", init_done, cfg_cnt == 3);
      chk("id_err", id_err, id_bad);
      if (wrt) begin
        exp_c = exp_cmd(n_txn);
        chk("wrt_width", prev_wrt, 0);
        chk("wrt_outstanding", pend, 0);
        chk("wrt_with_done", done, 0);
        chk("wrt_after_id_err", id_bad, 0);
        chk("cmd", cmd, exp_c);
        if (n_txn == 0) chk("first_wrt_cycle", rel, PW);
        if (exp_c == 16'hA600) chk("yaw_read_needs_int", int_h[2], 1);
        pend = 1; pend_cmd = exp_c; n_txn++;
      end else if (pend) chk("cmd_hold", cmd, pend_cmd);
      vld_due = 0;
      if (done && pend && !wrt) begin
        if (pend_cmd == 16'h8F00) id_bad = rd_data[7:0] != 8'h6A;
        else if (pend_cmd == 16'hA600) m_yl = rd_data[7:0];
        else if (pend_cmd == 16'hA700) begin m_yaw = {rd_data[7:0], m_yl}; vld_due = 1; end
        else cfg_cnt++;
        pend = 0;
      end
      prev_wrt = wrt;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  int n0;
  initial begin
    id_val = 8'h6B;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 300 && !id_err; i++) tick();
    chk("id_mismatch_err", id_err, 1);
    chk("id_mismatch_no_init", init_done, 0);
    chk("id_first_cmd", wlog.size() > 0 ? wlog[0] : 16'h0, 16'h8F00);
    chk("id_first_rel", first_rel, 16);
    n0 = wrt_total;
    repeat (10000) tick();
    chk("halt_no_wrt", wrt_total - n0, 0);
    chk("halt_init_done", init_done, 0);

    rst_n = 1'b0; id_val = 8'h6A;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 300 && wlog.size() < 3; i++) tick();
    chk("cfg1_reached", wlog.size(), 3);
    int_pulse = 1; tick(); int_pulse = 0;
    for (int i = 0; i < 300 && !init_done; i++) tick();
    chk("init_done_set", init_done, 1);
    chk("init_cmd0", wlog[0], 16'h8F00);
    chk("init_cmd1", wlog[1], 16'h0D02);
    chk("init_cmd2", wlog[2], 16'h1160);
    chk("init_cmd3", wlog[3], 16'h1440);
    chk("init_first_rel", first_rel, 16);
    repeat (20) tick();
    chk("cfg_int_ignored", wlog.size(), 4);

    yl_val = 8'h34; yh_val = 8'h12; int_hold = 1;
    for (int i = 0; i < 300 && !vld; i++) tick();
    chk("yaw_vld", vld, 1);
    chk("yaw_1234", yaw_rt, 16'h1234);
    chk("yaw_cmd_lo", wlog[4], 16'hA600);
    chk("yaw_cmd_hi", wlog[5], 16'hA700);
    tick();
    chk("vld_one_cycle", vld, 0);
    int_hold = 0;
    repeat (40) tick();
    chk("yaw_hold", yaw_rt, 16'h1234);
    chk("one_extra_pair_max", wlog.size() <= 8, 1);

    lat_fix = 0; rand_int = 1; rand_yaw = 1; n0 = vld_cnt;
    repeat (3000) tick();
    chk("random_vld_activity", vld_cnt - n0 > 10, 1);

    lat_fix = 1;
    for (int i = 0; i < 2000 && !(wlog.size() > 0 && wlog[$] == 16'hA700 && s_pend); i++) tick();
    chk("rd_yh_found", wlog.size() > 0 && wlog[$] == 16'hA700 && s_pend, 1);
    rand_int = 0; rst_n = 1'b0;
    tick();
    chk("midrst_wrt", wrt, 0); chk("midrst_cmd", cmd, 0); chk("midrst_yaw", yaw_rt, 0);
    chk("midrst_vld", vld, 0); chk("midrst_init", init_done, 0); chk("midrst_id_err", id_err, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 300 && !init_done; i++) tick();
    chk("restart_init_done", init_done, 1);
    chk("restart_first_cmd", wlog[0], 16'h8F00);
    chk("restart_first_rel", first_rel, 16);
    chk("restart_cmd_count", wlog.size(), 4);
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
